// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and transfer-size helper for the
// AHB-APB bridge front-end.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    function automatic logic [7:0] size_to_bytes(input logic [2:0] size);
        return 8'd1 << size;
    endfunction

endpackage

// File: rtl/ahb_timeout_cnt.sv
// Purpose: wait-cycle counter with clear/enable and a terminal-count done flag.
// Latency: done is combinational in the cycle the count reaches limit-1.
// Backpressure: none; the count freezes at the terminal value while enabled.
module ahb_timeout_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // done fires on the limit-th enabled cycle after a clear
    assign done = en && (cnt == limit - CNT_W'(1));

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !done) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ahb_slave_pipe.sv
// Purpose: AHB-Lite slave front-end forwarding decoded transfers to a valid/ready backend.
// Latency: >=1 wait state for writes, >=2 for reads; errors take a two-cycle ERROR response.
// Backpressure: Hready_out held low while req_ready/rsp_valid pending, bounded by RSP_TIMEOUT.
// Optional: AHB_SLV_SIZE_CHECK_EN rejects oversize or misaligned transfers with ERROR.
module ahb_slave_pipe
    import ahb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] ADDR_LO     = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] ADDR_HI     = 32'h8C00_0000,
    parameter int                RSP_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              Hreset,
    input  logic              Hwrite,
    input  logic [2:0]        Hsize,
    input  logic [1:0]        Htrans,
    input  logic              Hready_in,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [2:0]        Hburst,
    input  logic [DATA_W-1:0] Hwdata,
    output logic              Hready_out,
    output logic [1:0]        Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [2:0]        req_size,
    output logic [2:0]        req_burst,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    input  logic              rsp_err
);

    slv_state_e state;
    slv_state_e state_nxt;
    logic       accept;
    logic       in_range;
    logic       size_bad;
    logic       to_en;
    logic       to_done;

    assign accept = Hready_in
                 && (htrans_e'(Htrans) inside {HTRANS_NONSEQ, HTRANS_SEQ})
                 && (state == ST_IDLE || state == ST_ERR2);

    assign in_range = (Haddr >= ADDR_LO) && (Haddr < ADDR_HI);

`ifdef AHB_SLV_SIZE_CHECK_EN
    localparam int MAX_SIZE = $clog2(DATA_W / 8);
    logic [7:0] size_bytes;

    assign size_bytes = size_to_bytes(Hsize);
    assign size_bad   = (int'(Hsize) > MAX_SIZE)
                     || ((Haddr[7:0] & (size_bytes - 8'd1)) != 8'd0);
`else
    assign size_bad = 1'b0;
`endif

    assign req_wdata = Hwdata;
    assign to_en     = (state == ST_REQ) || (state == ST_RSP);

    ahb_timeout_cnt #(
        .CNT_W (16)
    ) u_timeout (
        .clock (clock),
        .rst   (Hreset),
        .clr   (accept),
        .en    (to_en),
        .limit (16'(RSP_TIMEOUT)),
        .done  (to_done)
    );

    // A real handshake or response in the timeout cycle wins over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    state_nxt = (in_range && !size_bad) ? ST_REQ : ST_ERR1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (req_ready) begin
                    if (req_write) begin
                        state_nxt = rsp_err ? ST_ERR1 : ST_IDLE;
                    end else begin
                        state_nxt = ST_RSP;
                    end
                end else if (to_done) begin
                    state_nxt = ST_ERR1;
                end
            end
            ST_RSP: begin
                if (rsp_valid) begin
                    state_nxt = rsp_err ? ST_ERR1 : ST_IDLE;
                end else if (to_done) begin
                    state_nxt = ST_ERR1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (Hreset) begin
            state      <= ST_IDLE;
            Hready_out <= 1'b1;
            Hresp      <= HRESP_OKAY;
            Hrdata     <= '0;
            req_valid  <= 1'b0;
            req_write  <= 1'b0;
            req_addr   <= '0;
            req_size   <= '0;
            req_burst  <= '0;
        end else begin
            state      <= state_nxt;
            Hready_out <= (state_nxt == ST_IDLE) || (state_nxt == ST_ERR2);
            Hresp      <= ((state_nxt == ST_ERR1) || (state_nxt == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
            req_valid  <= (state_nxt == ST_REQ);
            if (accept && in_range && !size_bad) begin
                req_write <= Hwrite;
                req_addr  <= Haddr;
                req_size  <= Hsize;
                req_burst <= Hburst;
            end
            // read data is loaded even when the backend flags an error
            if (state == ST_RSP && rsp_valid) begin
                Hrdata <= rsp_rdata;
            end
        end
    end

endmodule

// File: doc/ahb_slave_pipe.md
Name: ahb_slave_pipe

Overview:
Parametrised AHB-Lite slave front-end for the AHB-APB bridge. It samples AHB address phases and forwards each valid transfer to a backend over a valid/ready request channel with a separate read-response channel. It drives Hready_out, Hresp and Hrdata, with range checking, backend-error propagation and a response timeout. It sits between the AHB master side and the bridge FSM/APB backend.

Parameters:
ADDR_W, 32, width of Haddr/req_addr
DATA_W, 32, width of Hwdata/Hrdata (32 or 64)
ADDR_LO, 32'h8000_0000, lowest decoded address (inclusive)
ADDR_HI, 32'h8C00_0000, upper decode bound (exclusive)
RSP_TIMEOUT, 255, wait cycles in REQ+RSP before forced ERROR (1..65535)

Ports:
clock in 1 — sole clock, posedge
Hreset in 1 — synchronous, active-high reset
Hwrite in 1 — transfer direction, 1=write
Hsize in 3 — transfer size
Htrans in 2 — IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
Hready_in in 1 — bus ready; address phase valid only when high
Haddr in ADDR_W — transfer address
Hburst in 3 — burst type; forwarded only
Hwdata in DATA_W — write data, data phase
Hready_out out 1 — slave ready
Hresp out 2 — OKAY=00, ERROR=01
Hrdata out DATA_W — read data, registered
req_valid out 1 — backend request valid
req_ready in 1 — backend accepts request
req_write out 1; req_addr out ADDR_W; req_size out 3; req_burst out 3 — captured address-phase fields
req_wdata out DATA_W — equals Hwdata (combinational pass-through)
rsp_valid in 1 — read data / completion valid
rsp_rdata in DATA_W — read data
rsp_err in 1 — backend error, qualified by rsp_valid or by req_ready on writes

Behaviour:
- Reset (Hreset=1 at posedge): state=IDLE, Hready_out=1, Hresp=00, Hrdata=0, req_valid=0, timeout counter=0, captured fields=0. Mid-transfer reset abandons the transfer without a response.
- Address phase is accepted when Hready_in=1, Htrans[1]=1 and state is IDLE or ERR2. BUSY and IDLE transfers get a zero-wait OKAY.
- States: IDLE, REQ, RSP, ERR1, ERR2. Hready_out=1 only in IDLE and ERR2. Hresp=01 in ERR1 and ERR2, otherwise 00.
- IDLE/ERR2: on an accepted phase, if ADDR_LO<=Haddr<ADDR_HI, capture the fields and go to REQ; otherwise go to ERR1. With no accepted phase, go to IDLE.
- REQ: req_valid=1.
  - On req_ready with write: go to IDLE, or ERR1 if rsp_err.
  - On req_ready with read: go to RSP.
  - rsp_valid in REQ is ignored.
- RSP: on rsp_valid, Hrdata<=rsp_rdata and go to IDLE, or ERR1 if rsp_err (Hrdata still loaded).
- ERR1 -> ERR2 unconditionally. This gives a two-cycle ERROR response.
- Latency: minimum 1 wait state per transfer (address T0, REQ at T1, Hready_out=1 at T2 on immediate req_ready for a write). Reads take at least 2 wait states.
- Timeout: counter clears on REQ entry and increments each cycle in REQ/RSP. On reaching RSP_TIMEOUT: drop req_valid and go to ERR1. A later rsp_valid outside RSP is ignored.
- Back-to-back: a new address phase is sampled in the same cycle Hready_out=1 completes the prior transfer.
- Hrdata holds its value across writes and errors.

Optional Feature:
AHB_SLV_SIZE_CHECK_EN — when defined, an accepted transfer with Hsize>log2(DATA_W/8), or with Haddr not aligned to Hsize, goes to ERR1 with no backend request. When undefined, such transfers are forwarded unmodified.

Decomposition:
- Package ahb_pkg:
  - htrans_e, hburst_e, hresp constants (OKAY/ERROR)
  - slave state enum
  - size-to-bytes function
- Sub-module ahb_timeout_cnt: clear/enable/limit counter with a done pulse.

Test Plan:
- Write 0x8000_0010, data 0xDEAD_BEEF, req_ready=1 at T1 -> req_valid at T1 with req_wdata=0xDEAD_BEEF; Hready_out=0 at T1, 1 at T2; Hresp=00.
- Read 0x8000_0020, req_ready T1, rsp_valid T3 with 0x1234_5678 -> Hready_out=1 at T4, Hrdata=0x1234_5678.
- Write to 0x9000_0000 -> no req_valid; Hresp=01 with Hready_out=0, then Hresp=01 with Hready_out=1; next cycle IDLE/OKAY.
- Read, RSP_TIMEOUT=8, no rsp_valid -> req_valid drops after 8 cycles; two-cycle ERROR; later rsp_valid ignored.
- Four back-to-back NONSEQ/SEQ writes with req_ready held high -> each transfer completes with exactly one wait state; req_addr sequence matches Haddr.
- Hreset=1 during RSP -> next cycle Hready_out=1, Hresp=00, req_valid=0, Hrdata=0; with AHB_SLV_SIZE_CHECK_EN, Hsize=3'b011 on 32-bit -> ERROR.
